// File: rtl/alu_seq_n_bit.sv
// Registered n-bit ALU with a start/done handshake, shift/rotate modes and an
// iterative N-cycle shift-add multiplier; all results and flags are held in output registers.
module alu_seq_n_bit #(
  parameter int unsigned N   = 8,
  parameter int unsigned SHW = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         CB_in,
  input  logic [3:0]   Mode,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] Result,
  output logic [N-1:0] Result_hi,
  output logic         CB_out,
  output logic         Z,
  output logic         Neg,
  output logic         V,
  output logic         err
);

  localparam int unsigned CW = $clog2(N);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_MUL  = 2'd2;

  localparam logic [3:0] M_ADD = 4'b0000;
  localparam logic [3:0] M_SUB = 4'b0001;
  localparam logic [3:0] M_AND = 4'b0010;
  localparam logic [3:0] M_OR  = 4'b0011;
  localparam logic [3:0] M_XOR = 4'b0100;
  localparam logic [3:0] M_NOT = 4'b0101;
  localparam logic [3:0] M_INC = 4'b0110;
  localparam logic [3:0] M_DEC = 4'b0111;
  localparam logic [3:0] M_SHL = 4'b1000;
  localparam logic [3:0] M_SHR = 4'b1001;
  localparam logic [3:0] M_MUL = 4'b1010;
  localparam logic [3:0] M_ROL = 4'b1011;

  logic [1:0]    state_q, state_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic          cb_q, cb_d;
  logic [3:0]    mode_q, mode_d;
  logic [N-1:0]  acc_hi_q, acc_hi_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [N-1:0]  result_q, result_d;
  logic [N-1:0]  result_hi_q, result_hi_d;
  logic          cb_out_q, cb_out_d;
  logic          z_q, z_d;
  logic          neg_q, neg_d;
  logic          v_q, v_d;
  logic          err_q, err_d;

  logic [N:0]     ext;
  logic [N-1:0]   alu_res;
  logic           alu_cb;
  logic           alu_v;
  logic           alu_err;
  logic [SHW-1:0] sh;
  logic [31:0]    rot_r;
  logic [N:0]     mul_sum;
  logic [N-1:0]   mul_hi;
  logic [N-1:0]   mul_lo;

  // Single-cycle datapath, evaluated from the captured operands
  always_comb begin
    ext     = '0;
    alu_res = '0;
    alu_cb  = 1'b0;
    alu_v   = 1'b0;
    alu_err = 1'b0;
    sh      = b_q[SHW-1:0];
    rot_r   = 32'(N) - 32'(sh);
    case (mode_q)
      M_ADD: begin
        ext     = {1'b0, a_q} + {1'b0, b_q} + (N+1)'(cb_q);
        alu_res = ext[N-1:0];
        alu_cb  = ext[N];
        alu_v   = (a_q[N-1] == b_q[N-1]) && (alu_res[N-1] != a_q[N-1]);
      end
      M_SUB: begin
        // bit N of the wrapped difference is the unsigned borrow
        ext     = {1'b0, a_q} - {1'b0, b_q} - (N+1)'(cb_q);
        alu_res = ext[N-1:0];
        alu_cb  = ext[N];
        alu_v   = (a_q[N-1] != b_q[N-1]) && (alu_res[N-1] != a_q[N-1]);
      end
      M_AND: alu_res = a_q & b_q;
      M_OR:  alu_res = a_q | b_q;
      M_XOR: alu_res = a_q ^ b_q;
      M_NOT: alu_res = ~a_q;
      M_INC: begin
        alu_res = a_q + N'(1);
        alu_cb  = &a_q;
        alu_v   = (a_q == {1'b0, {(N-1){1'b1}}});
      end
      M_DEC: begin
        alu_res = a_q - N'(1);
        alu_cb  = (a_q == '0);
        alu_v   = (a_q == {1'b1, {(N-1){1'b0}}});
      end
      M_SHL: begin
        // the extra bit catches the last bit shifted out (0 for shift 0)
        ext     = {1'b0, a_q} << sh;
        alu_res = ext[N-1:0];
        alu_cb  = ext[N];
      end
      M_SHR: begin
        ext     = {a_q, 1'b0} >> sh;
        alu_res = ext[N:1];
        alu_cb  = ext[0];
      end
      M_ROL: alu_res = (a_q << sh) | (a_q >> rot_r);
      M_MUL: alu_res = '0;
      default: alu_err = 1'b1;
    endcase
  end

  // One shift-add multiplier iteration: b_q is the multiplier / low accumulator
  always_comb begin
    mul_sum = {1'b0, acc_hi_q} + (b_q[0] ? {1'b0, a_q} : (N+1)'(0));
    mul_hi  = mul_sum[N:1];
    mul_lo  = {mul_sum[0], b_q[N-1:1]};
  end

  // Next-state and output-register logic
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    cb_d        = cb_q;
    mode_d      = mode_q;
    acc_hi_d    = acc_hi_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    cb_out_d    = cb_out_q;
    z_d         = z_q;
    neg_d       = neg_q;
    v_d         = v_q;
    err_d       = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d      = A;
          b_d      = B;
          cb_d     = CB_in;
          mode_d   = Mode;
          acc_hi_d = '0;
          cnt_d    = CW'(N - 1);
          busy_d   = 1'b1;
          state_d  = (Mode == M_MUL) ? S_MUL : S_EXEC;
        end
      end
      S_EXEC: begin
        result_d    = alu_res;
        result_hi_d = '0;
        cb_out_d    = alu_cb;
        z_d         = (alu_res == '0);
        neg_d       = alu_res[N-1];
        v_d         = alu_v;
        err_d       = alu_err;
        done_d      = 1'b1;
        busy_d      = 1'b0;
        state_d     = S_IDLE;
      end
      S_MUL: begin
        acc_hi_d = mul_hi;
        b_d      = mul_lo;
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          result_d    = mul_lo;
          result_hi_d = mul_hi;
          cb_out_d    = (mul_hi != '0);
          z_d         = (mul_hi == '0) && (mul_lo == '0);
          neg_d       = mul_lo[N-1];
          v_d         = 1'b0;
          err_d       = 1'b0;
          done_d      = 1'b1;
          busy_d      = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      cb_q        <= 1'b0;
      mode_q      <= '0;
      acc_hi_q    <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
      result_hi_q <= '0;
      cb_out_q    <= 1'b0;
      z_q         <= 1'b0;
      neg_q       <= 1'b0;
      v_q         <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cb_q        <= cb_d;
      mode_q      <= mode_d;
      acc_hi_q    <= acc_hi_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      cb_out_q    <= cb_out_d;
      z_q         <= z_d;
      neg_q       <= neg_d;
      v_q         <= v_d;
      err_q       <= err_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign Result    = result_q;
  assign Result_hi = result_hi_q;
  assign CB_out    = cb_out_q;
  assign Z         = z_q;
  assign Neg       = neg_q;
  assign V         = v_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_seq_n_bit.sv
// Directed self-checking bench for alu_seq_n_bit (N=8): flags, latency, MUL timing,
// ignored start while busy, back-to-back issue and asynchronous abort.
module tb_alu_seq_n_bit;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] A;
  logic [7:0] B;
  logic       CB_in;
  logic [3:0] Mode;
  logic       busy;
  logic       done;
  logic [7:0] Result;
  logic [7:0] Result_hi;
  logic       CB_out;
  logic       Z;
  logic       Neg;
  logic       V;
  logic       err;

  int n_vec;
  int n_err;

  alu_seq_n_bit #(.N(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .A         (A),
    .B         (B),
    .CB_in     (CB_in),
    .Mode      (Mode),
    .busy      (busy),
    .done      (done),
    .Result    (Result),
    .Result_hi (Result_hi),
    .CB_out    (CB_out),
    .Z         (Z),
    .Neg       (Neg),
    .V         (V),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [7:0] res, input logic [7:0] hi,
                            input logic cbo, input logic z, input logic neg, input logic v,
                            input logic e);
    chk({tag, ".Result"},    32'(Result),    32'(res));
    chk({tag, ".Result_hi"}, 32'(Result_hi), 32'(hi));
    chk({tag, ".CB_out"},    32'(CB_out),    32'(cbo));
    chk({tag, ".Z"},         32'(Z),         32'(z));
    chk({tag, ".Neg"},       32'(Neg),       32'(neg));
    chk({tag, ".V"},         32'(V),         32'(v));
    chk({tag, ".err"},       32'(err),       32'(e));
  endtask

  // Called #1 after an edge; returns #1 after the accepting edge with operands scrambled
  task automatic issue(input logic [3:0] m, input logic [7:0] a, input logic [7:0] b,
                       input logic cb);
    Mode  = m;
    A     = a;
    B     = b;
    CB_in = cb;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    A     = ~a;
    B     = ~b;
    CB_in = ~cb;
    Mode  = 4'b0000;
  endtask

  task automatic run1(input string tag, input logic [3:0] m, input logic [7:0] a,
                      input logic [7:0] b, input logic cb);
    issue(m, a, b, cb);
    chk({tag, ".busy_k"}, 32'(busy), 32'd1);
    chk({tag, ".done_k"}, 32'(done), 32'd0);
    @(posedge clk);
    #1;
    chk({tag, ".done"}, 32'(done), 32'd1);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
  endtask

  task automatic run_mul(input string tag, input logic [7:0] a, input logic [7:0] b);
    int cyc;
    cyc = 0;
    issue(4'b1010, a, b, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      if (i == 3) begin
        start = 1'b1;
        Mode  = 4'b0000;
        A     = 8'h11;
        B     = 8'h22;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done) begin
        cyc = i;
        break;
      end
      if (i == 4) chk({tag, ".busy_mid"}, 32'(busy), 32'd1);
    end
    chk({tag, ".latency"}, 32'(cyc), 32'd8);
    chk({tag, ".busy_done"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int ndone;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    start = 1'b0;
    A     = '0;
    B     = '0;
    CB_in = 1'b0;
    Mode  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    expect_out("rst", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run1("add_ff_01", 4'b0000, 8'hFF, 8'h01, 1'b0);
    expect_out("add_ff_01", 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    run1("add_7f_01", 4'b0000, 8'h7F, 8'h01, 1'b0);
    expect_out("add_7f_01", 8'h80, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk("hold.done", 32'(done), 32'd0);
    chk("hold.Result", 32'(Result), 32'h80);

    run1("sub_03_05_1", 4'b0001, 8'h03, 8'h05, 1'b1);
    expect_out("sub_03_05_1", 8'hFD, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

    run1("sub_80_01", 4'b0001, 8'h80, 8'h01, 1'b0);
    expect_out("sub_80_01", 8'h7F, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    run1("dec_00", 4'b0111, 8'h00, 8'h00, 1'b0);
    expect_out("dec_00", 8'hFF, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

    run1("xor", 4'b0100, 8'hA5, 8'h0F, 1'b1);
    expect_out("xor", 8'hAA, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    run1("shl_81_1", 4'b1000, 8'h81, 8'h01, 1'b0);
    expect_out("shl_81_1", 8'h02, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    run1("shr_81_1", 4'b1001, 8'h81, 8'h01, 1'b0);
    expect_out("shr_81_1", 8'h40, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    run1("rol_81_1", 4'b1011, 8'h81, 8'h01, 1'b0);
    expect_out("rol_81_1", 8'h03, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    run1("rsv_f", 4'b1111, 8'h12, 8'h34, 1'b0);
    expect_out("rsv_f", 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);

    // previous err/Result must hold throughout the multiply
    run_mul("mul_ff_ff", 8'hFF, 8'hFF);
    expect_out("mul_ff_ff", 8'h01, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    ndone = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    chk("mul_ff_ff.no_queued_start", 32'(ndone), 32'd0);

    run_mul("mul_03_05", 8'h03, 8'h05);
    expect_out("mul_03_05", 8'h0F, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    run_mul("mul_00_37", 8'h00, 8'h37);
    expect_out("mul_00_37", 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    run_mul("mul_ff_ff2", 8'hFF, 8'hFF);

    // Asynchronous abort during the 4th multiply iteration
    issue(4'b1010, 8'h12, 8'h34, 1'b0);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("abort.busy", 32'(busy), 32'd0);
    chk("abort.done", 32'(done), 32'd0);
    expect_out("abort", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ndone = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    chk("abort.no_done", 32'(ndone), 32'd0);

    run1("add_2_3", 4'b0000, 8'h02, 8'h03, 1'b0);
    expect_out("add_2_3", 8'h05, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // start issued in the done cycle is accepted
    run1("inc_7f_b2b", 4'b0110, 8'h7F, 8'h00, 1'b0);
    expect_out("inc_7f_b2b", 8'h80, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    run1("inc_ff", 4'b0110, 8'hFF, 8'h00, 1'b0);
    expect_out("inc_ff", 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
